// File: rtl/dmac_pkg.sv
// ------------------------------------------------------------------
// dmac_pkg: shared DMAC state encoding and data width.  Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package dmac_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int DMAC_DATA_W = 16;

endpackage

`default_nettype wire

// File: rtl/dma_fifo_drain.sv
// ------------------------------------------------------------------
// dma_fifo_drain: pops channel-FIFO words and writes them to consecutive
// addresses; optional ack watchdog via DMA_DRAIN_TIMEOUT_EN.  Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module dma_fifo_drain
  import dmac_pkg::*;
#(
  parameter int DATA_W  = DMAC_DATA_W,
  parameter int ADDR_W  = 16,
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  xfer_len,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              err
);

  if (TIMEOUT < 1) begin : g_timeout_check
    $error("dma_fifo_drain: TIMEOUT must be at least 1");
  end

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  rem_q;
  logic [DATA_W-1:0] wdata_q;
  logic              accept;
  logic              wd_hit;

  assign accept = (state == S_IDLE) && start;

  always_comb begin
    state_nxt  = state;
    fifo_rd_en = 1'b0;
    mem_req    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = (xfer_len == '0) ? S_DONE : S_FETCH;
      end
      S_FETCH: begin
        busy       = 1'b1;
        fifo_rd_en = !fifo_empty;
        if (!fifo_empty) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        // An ack arriving on the watchdog's last cycle still completes the word.
        if (mem_ack)     state_nxt = (rem_q == LEN_W'(1)) ? S_DONE : S_FETCH;
        else if (wd_hit) state_nxt = S_DONE;
      end
      default: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign mem_we    = mem_req;
  assign mem_addr  = mem_req ? addr_q  : '0;
  assign mem_wdata = mem_req ? wdata_q : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_q <= dst_addr;
        rem_q  <= xfer_len;
      end
      if (fifo_rd_en) wdata_q <= fifo_dout;
      if (state == S_WRITE && mem_ack) begin
        addr_q <= addr_q + 1'b1;
        rem_q  <= rem_q - 1'b1;
      end
    end
  end

`ifdef DMA_DRAIN_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wd_cnt;
  logic             err_q;

  assign wd_hit = (state == S_WRITE) && !mem_ack && (wd_cnt == CNT_W'(TIMEOUT - 1));
  assign err    = err_q;

  // The pop edge is the only way into WRITE, so it restarts the watchdog.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (fifo_rd_en)                      wd_cnt <= '0;
      else if (state == S_WRITE && !mem_ack) wd_cnt <= wd_cnt + 1'b1;
      if (accept)      err_q <= 1'b0;
      else if (wd_hit) err_q <= 1'b1;
    end
  end
`else
  assign wd_hit = 1'b0;
  assign err    = 1'b0;
`endif

endmodule

`default_nettype wire
